// File: rtl/wb_arbiter_pkg.sv
// Shared CPU writeback definitions: requester count, payload layout and
// source indices for the result producers feeding the writeback port.
package wb_arbiter_pkg;

  localparam int NUM_WB_REQ = 3;
  localparam int WB_DATA_W  = 32;
  localparam int WB_RD_W    = 5;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MUL = 2'd1;
  localparam logic [1:0] SRC_LSU = 2'd2;

  typedef struct packed {
    logic [WB_RD_W-1:0]   rd;
    logic [WB_DATA_W-1:0] value;
    logic                 wen;
  } wb_payload_t;

  // x0 is hardwired to zero, so a write to it must never reach the regfile.
  function automatic logic wb_wen_eff(input logic wen, input logic [WB_RD_W-1:0] rd);
    return wen & (rd != '0);
  endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin grant: first requester at or after ptr, scanning upward
// modulo N. Produces a one-hot grant, or zero when nobody requests.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N     = NUM_WB_REQ,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % N)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one result producer per cycle round-robin into
// a single registered writeback slot, and counts arbitration-loss cycles.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  parameter int DATA_W  = WB_DATA_W,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][WB_RD_W-1:0] req_rd,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_value,
  input  logic [NUM_REQ-1:0]             req_wen,
  input  logic                           flush,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [WB_RD_W-1:0]             wb_rd,
  output logic [DATA_W-1:0]              wb_value,
  output logic                           wb_wen,
  output logic [SRC_W-1:0]               wb_src,
  output logic [31:0]                    stall_cnt
);

  logic                 wb_valid_q, wb_valid_d;
  logic [WB_RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]    wb_value_q, wb_value_d;
  logic                 wb_wen_q, wb_wen_d;
  logic [SRC_W-1:0]     wb_src_q, wb_src_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;

  logic [NUM_REQ-1:0]   grant;
  logic [SRC_W-1:0]     gnt_idx;
  logic                 load_en;
  logic [2:0]           n_valid;
  logic [2:0]           stall_inc;
  logic [32:0]          stall_sum;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(SRC_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign load_en   = !reset && !flush && (!wb_valid_q || wb_ready) && (|req_valid);
  assign req_ready = load_en ? grant : '0;

  always_comb begin
    gnt_idx    = '0;
    wb_rd_d    = wb_rd_q;
    wb_value_d = wb_value_q;
    wb_wen_d   = wb_wen_q;
    wb_src_d   = wb_src_q;
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = wb_valid_q;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = SRC_W'(i);
    end

    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (load_en) begin
      wb_valid_d = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          wb_rd_d    = req_rd[i];
          wb_value_d = req_value[i];
          wb_wen_d   = wb_wen_eff(req_wen[i], req_rd[i]);
        end
      end
      wb_src_d = gnt_idx;
      rr_ptr_d = SRC_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  // Flush cycles are not arbitration losses; nobody competes for the slot.
  always_comb begin
    n_valid = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_valid = n_valid + 3'(req_valid[i]);
    end
    stall_inc = 3'd0;
    if (!flush) stall_inc = n_valid - 3'(load_en);
    stall_sum   = {1'b0, stall_cnt_q} + 33'(stall_inc);
    stall_cnt_d = stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_value_q  <= '0;
      wb_wen_q    <= 1'b0;
      wb_src_q    <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_value_q  <= wb_value_d;
      wb_wen_q    <= wb_wen_d;
      wb_src_q    <= wb_src_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_value  = wb_value_q;
  assign wb_wen    = wb_wen_q;
  assign wb_src    = wb_src_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of result producers sharing the writeback port (2..4).
REQ-002 SHALL have parameter DATA_W, default 32, result width.
REQ-003 SHALL have one clock and a synchronous, active-high reset, named clock and reset; all state updates on the rising edge of clock.
REQ-004 clock  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester result valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 req_rd  input  NUM_REQ x 5  destination register index.
REQ-009 req_value  input  NUM_REQ x DATA_W  result value.
REQ-010 req_wen  input  NUM_REQ  register write enable.
REQ-011 flush  input  1  pipeline flush, kills the held result.
REQ-012 wb_valid  output  1  registered writeback valid.
REQ-013 wb_ready  input  1  downstream writeback stage accepts.
REQ-014 wb_rd / wb_value / wb_wen  output  5 / DATA_W / 1  registered writeback payload.
REQ-015 wb_src  output  clog2(NUM_REQ)  index of the producer of the held result.
REQ-016 stall_cnt  output  32  performance count of arbitration-loss cycles.

Function
REQ-017 Output register SHALL load when load_en = (!wb_valid | wb_ready) & !flush & (|req_valid).
REQ-018 Exactly one requester SHALL be granted per load: the first valid index at or after rr_ptr, scanning upward modulo NUM_REQ.
REQ-019 req_ready[i] SHALL be 1 only for the granted index in a cycle where load_en is 1; req_ready SHALL be 0 whenever flush is 1.
REQ-020 Latency SHALL be 1 cycle: a transfer accepted at edge N drives wb_valid=1 with its payload after edge N; throughput SHALL be one result per cycle with wb_ready held at 1.
REQ-021 On load, rr_ptr SHALL become (granted index + 1) mod NUM_REQ; rr_ptr SHALL be unchanged otherwise, including on flush.
REQ-022 wb_wen SHALL be registered as req_wen & (req_rd != 0); writes to x0 SHALL pass through as wb_valid=1, wb_wen=0.
REQ-023 When wb_valid=1 and wb_ready=1 with no new request, wb_valid SHALL clear after the edge.
REQ-024 When wb_valid=1 and wb_ready=0, the payload and wb_src SHALL hold stable and all req_ready SHALL be 0.
REQ-025 flush SHALL clear wb_valid at the next edge regardless of wb_ready; a request present during flush SHALL NOT be accepted.
REQ-026 stall_cnt SHALL increment by the number of valid requesters not granted in that cycle (including every valid requester when load_en=0 and flush=0), saturating at 0xFFFF_FFFF.
REQ-027 Payload registers SHALL load only on load_en and SHALL hold their value otherwise.

Reset
REQ-028 Reset SHALL set wb_valid=0, wb_rd=0, wb_value=0, wb_wen=0, wb_src=0, rr_ptr=0, stall_cnt=0; req_ready SHALL be 0 while reset=1.
REQ-029 Reset asserted during a held, unaccepted result SHALL discard it; reset SHALL take priority over flush and load.

Structure
REQ-030 NUM_WB_REQ, the wb_payload_t struct {rd, value, wen}, and source-index constants SHALL reside in the shared CPU package.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant); wb_arbiter owns the pointer, output register and counter.

Verification
REQ-032 Single producer: req_valid=001, rd=5, value=0xDEADBEEF, wen=1, wb_ready=1 -> next cycle wb_valid=1, wb_rd=5, wb_value=0xDEADBEEF, wb_wen=1, wb_src=0.
REQ-033 Round-robin fairness: all three valid continuously, wb_ready=1, from reset -> grants 0,1,2,0,1,2; stall_cnt = 2 after the first cycle.
REQ-034 Backpressure: wb_valid=1, wb_ready=0 for 3 cycles with req_valid=010 -> payload stable, req_ready=000, stall_cnt +3; wb_ready=1 -> src 1 loaded the next cycle.
REQ-035 x0 write: rd=0, wen=1, value=0x12345678 -> wb_valid=1, wb_wen=0.
REQ-036 Flush: wb_valid=1, wb_ready=0, flush=1 with req_valid=100 -> wb_valid=0 next cycle, req_ready=000, rr_ptr unchanged.
REQ-037 Reset mid-hold: wb_valid=1, wb_ready=0, reset=1 for 1 cycle -> all outputs 0, stall_cnt=0, rr_ptr=0.
